if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage producer that feeds the IF/ID pipeline register (pc_out/instruction_out drive its pc_in/instruction_in).
- Holds the fetch PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Presents one fetched instruction at a time and holds it while the pipeline stalls.
- Handles redirects (taken branch/jump, flush) and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- NOP_INSTR, 32'h00000013, value driven on instruction_out when no valid instruction is presented.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; same signal that stalls IF/ID.
- redirect  in  1  flush/branch taken; load redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 00).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= fetch PC).
- imem_gnt  in  1  memory accepts request this cycle (meaningful only with imem_req).
- imem_rvalid  in  1  response valid; at most one per accepted request, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction.
- pc_out  out  32  PC of presented instruction.
- instruction_out  out  32  presented instruction; NOP_INSTR when valid_out=0.
- valid_out  out  1  pc_out/instruction_out hold a real instruction.

Behaviour:
- Reset (async, reset_n=0): state=REQ, fetch_pc=RESET_PC, pc_out=0, instruction_out=NOP_INSTR, valid_out=0.
- imem_req=1 only in state REQ; imem_addr=fetch_pc always. Both are combinational from registered state.
- State REQ:
  - redirect=1, imem_gnt=1 → fetch_pc<=redirect_pc, go DROP (granted old request must be discarded).
  - redirect=1, imem_gnt=0 → fetch_pc<=redirect_pc, stay REQ (request address may change while not granted).
  - imem_gnt=1 → WAIT.
- State WAIT:
  - redirect=1 with imem_rvalid=1 → discard rdata, fetch_pc<=redirect_pc, go REQ.
  - redirect=1 with imem_rvalid=0 → fetch_pc<=redirect_pc, go DROP.
  - imem_rvalid=1 → pc_out<=fetch_pc, instruction_out<=imem_rdata, valid_out<=1, go HOLD.
- State HOLD (instruction presented):
  - redirect=1 → valid_out<=0, instruction_out<=NOP_INSTR, fetch_pc<=redirect_pc, go REQ. Redirect beats stall.
  - stall=1 → hold all outputs unchanged.
  - stall=0 → instruction consumed at this edge. valid_out<=0, instruction_out<=NOP_INSTR, fetch_pc<=fetch_pc+4, go REQ.
- State DROP:
  - imem_rvalid=1 → discard, go REQ.
  - redirect=1 → fetch_pc<=redirect_pc; combined with imem_rvalid it still goes to REQ, otherwise stays DROP.
- Outputs in states other than HOLD: valid_out=0, instruction_out=NOP_INSTR, pc_out keeps its last value.
- fetch_pc+4 wraps modulo 2^32 (32'hFFFFFFFC → 0).
- imem_rvalid in REQ or HOLD is a protocol violation and is ignored.
- Never more than one outstanding request.
- Best-case throughput: REQ(gnt) → WAIT(rvalid) → HOLD(consume) = one instruction per 3 cycles.
- Reset asserted mid-transaction returns the unit to the reset state immediately. Any later stray rvalid arriving in REQ is ignored.

Test Plan:
- Reset then release, memory grants immediately and returns rdata=32'h00500093 one cycle later → imem_addr=0, then HOLD with pc_out=0, instruction_out=32'h00500093, valid_out=1; next request imem_addr=4.
- stall=1 for 3 cycles while in HOLD → outputs frozen, imem_req=0. On stall=0, the next request has imem_addr=fetch_pc+4.
- redirect=1 with redirect_pc=32'h00000103 while in WAIT, rvalid arrives 2 cycles later with junk → junk never appears on instruction_out (valid_out stays 0). Next imem_addr=32'h00000100.
- redirect in REQ in the same cycle as imem_gnt → unit enters DROP, discards the response, then requests redirect_pc.
- redirect and stall both high in HOLD → valid_out=0, instruction_out=32'h00000013, next imem_addr=redirect_pc.
- fetch_pc=32'hFFFFFFFC consumed with no stall → next imem_addr=0. Asserting reset_n=0 while in WAIT → state REQ and fetch_pc=RESET_PC asynchronously.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: single-outstanding
// request/grant/response handshake, one presented instruction at a time, redirect-safe.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  fetch_pc_next_s;
    logic [31:0]  pc_out_r;
    logic [31:0]  pc_out_next_s;
    logic [31:0]  instr_r;
    logic [31:0]  instr_next_s;
    logic         valid_r;
    logic         valid_next_s;
    logic [31:0]  redirect_tgt_s;

    // Fetch targets are word aligned; the low two bits of a redirect are dropped.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req        = (state_r == ST_REQ);
    assign imem_addr       = fetch_pc_r;
    assign pc_out          = pc_out_r;
    assign instruction_out = instr_r;
    assign valid_out       = valid_r;

    // Next-state and next-output decode; every path starts from "hold".
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        pc_out_next_s   = pc_out_r;
        instr_next_s    = instr_r;
        valid_next_s    = valid_r;
        case (state_r)
            ST_REQ: begin
                if (redirect) begin
                    // A request granted in the redirect cycle still returns data: drop it.
                    fetch_pc_next_s = redirect_tgt_s;
                    if (imem_gnt) begin
                        state_next_s = ST_DROP;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else if (imem_gnt) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_tgt_s;
                    if (imem_rvalid) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_DROP;
                    end
                end else if (imem_rvalid) begin
                    pc_out_next_s = fetch_pc_r;
                    instr_next_s  = imem_rdata;
                    valid_next_s  = 1'b1;
                    state_next_s  = ST_HOLD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    valid_next_s    = 1'b0;
                    instr_next_s    = NOP_INSTR;
                    fetch_pc_next_s = redirect_tgt_s;
                    state_next_s    = ST_REQ;
                end else if (stall) begin
                    state_next_s = ST_HOLD;
                end else begin
                    valid_next_s    = 1'b0;
                    instr_next_s    = NOP_INSTR;
                    fetch_pc_next_s = fetch_pc_r + 32'd4;
                    state_next_s    = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_tgt_s;
                end else begin
                    fetch_pc_next_s = fetch_pc_r;
                end
                if (imem_rvalid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s    = ST_REQ;
                fetch_pc_next_s = RESET_PC;
                valid_next_s    = 1'b0;
                instr_next_s    = NOP_INSTR;
            end
        endcase
    end

    // State and presented-instruction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_REQ;
            fetch_pc_r <= RESET_PC;
            pc_out_r   <= 32'h0000_0000;
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            pc_out_r   <= pc_out_next_s;
            instr_r    <= instr_next_s;
            valid_r    <= valid_next_s;
        end
    end

endmodule
